// File: rtl/sum_seq32.sv
// Byte-serial 32-bit adder/subtractor built around one 8-bit adder.
// Four byte cycles per operation, LSB byte first, registered results.

module my_sum (
  input  logic [7:0] Ain,
  input  logic [7:0] Bin,
  input  logic       Ci,
  output logic [7:0] Sout,
  output logic       Co
);

  // Plain 8-bit ripple add with carry in/out.
  assign {Co, Sout} = {1'b0, Ain} + {1'b0, Bin} + {8'b0, Ci};

endmodule

module sum_seq32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Ain,
  input  logic [31:0] Bin,
  input  logic        Ci,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [31:0] Sout,
  output logic        Co,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic        carry;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sub_r;
  logic [23:0] res;

  logic [7:0]  a_byte;
  logic [7:0]  b_byte;
  logic [7:0]  s8;
  logic        c8;
  logic        b31;

  // Select the current byte; subtraction feeds the inverted operand.
  assign a_byte = a_r[{idx, 3'b000} +: 8];
  assign b_byte = b_r[{idx, 3'b000} +: 8] ^ {8{sub_r}};
  assign b31    = b_r[31] ^ sub_r;

  my_sum u_add (
    .Ain  (a_byte),
    .Bin  (b_byte),
    .Ci   (carry),
    .Sout (s8),
    .Co   (c8)
  );

  // Control FSM, byte datapath and output registers.
  // Byte 3 goes straight to Sout so partial results never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      carry <= 1'b0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      sub_r <= 1'b0;
      res   <= 24'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sout  <= 32'd0;
      Co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= Ain;
            b_r   <= Bin;
            sub_r <= sub;
            carry <= sub ? 1'b1 : Ci;
            idx   <= 2'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c8;
          idx   <= idx + 2'd1;
          unique case (idx)
            2'd0: res[7:0]   <= s8;
            2'd1: res[15:8]  <= s8;
            2'd2: res[23:16] <= s8;
            2'd3: begin
              Sout  <= {s8, res};
              Co    <= c8;
              ovf   <= (a_r[31] == b31) &&
                       (s8[7] != a_r[31]);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
            default: ;
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_seq32.sv
// Self-checking bench for sum_seq32: directed cases plus random ops
// compared with an arithmetic reference model.

module tb_sum_seq32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] Ain;
  logic [31:0] Bin;
  logic        Ci;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] Sout;
  logic        Co;
  logic        ovf;

  int n_tests;
  int n_fail;

  logic [31:0] prev_s;
  logic        prev_c;
  logic        prev_o;

  sum_seq32 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .Ain  (Ain),
    .Bin  (Bin),
    .Ci   (Ci),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .Sout (Sout),
    .Co   (Co),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 32-bit arithmetic and signed range test.
  task automatic model(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic ci,
                       input logic sb,
                       output logic [31:0] s,
                       output logic co,
                       output logic ov);
    logic [32:0] t;
    longint r;
    if (!sb) begin
      t  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      s  = t[31:0];
      co = t[32];
      r  = longint'($signed(a)) + longint'($signed(b))
         + longint'(ci);
    end else begin
      s  = a - b;
      co = (a >= b);
      r  = longint'($signed(a)) - longint'($signed(b));
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  // mode 0: plain, 1: extra start pulse during RUN,
  // 2: reset asserted after two byte cycles.
  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic ci,
                        input logic sb,
                        input int mode,
                        input string tag);
    logic [31:0] es;
    logic        ec;
    logic        eo;
    int busy_cnt;
    int done_cnt;
    int done_at;
    int hold_bad;
    model(a, b, ci, sb, es, ec, eo);
    @(negedge clk);
    Ain = a; Bin = b; Ci = ci; sub = sb; start = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0; hold_bad = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      Ain = $urandom; Bin = $urandom;
      Ci = 1'($urandom); sub = 1'($urandom);
      if (mode == 1 && k == 2) start = 1'b1;
      if (mode == 2 && k == 3) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_out"},
              {30'd0, busy, done, Sout, Co, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
          @(negedge clk);
          if (done) done_cnt++;
        end
        check({tag, "_rst_nodone"}, 64'(done_cnt), 64'd0);
        prev_s = 32'd0; prev_c = 1'b0; prev_o = 1'b0;
        return;
      end
      if (busy) begin
        busy_cnt++;
        if (Sout !== prev_s || Co !== prev_c || ovf !== prev_o)
          hold_bad++;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
      end
    end
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_at"}, 64'(done_at), 64'd5);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_sout"}, 64'(Sout), 64'(es));
    check({tag, "_co"}, 64'(Co), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    prev_s = es; prev_c = ec; prev_o = eo;
  endtask

  initial begin
    logic [31:0] es;
    logic        ec;
    logic        eo;
    int dcnt;
    int second_at;
    n_tests = 0;
    n_fail  = 0;
    prev_s = 32'd0; prev_c = 1'b0; prev_o = 1'b0;
    rst = 1'b1; start = 1'b0;
    Ain = 32'd0; Bin = 32'd0; Ci = 1'b0; sub = 1'b0;
    #1;
    check("reset_async",
          {30'd0, busy, done, Sout, Co, ovf}, 64'd0);
    repeat (2) @(negedge clk);
    check("reset_hold",
          {30'd0, busy, done, Sout, Co, ovf}, 64'd0);
    rst = 1'b0;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, "add_ff");
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, "ripple");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "ovf_add");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, "ovf_sub");
    run_op(32'd5, 32'd7, 1'b1, 1'b1, 0, "borrow");
    run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1, "restart");
    run_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 2, "midrst");
    run_op(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0, 0, "post_rst");

    // Start held high: second acceptance in the first IDLE cycle.
    @(negedge clk);
    Ain = 32'h0000_1000; Bin = 32'h0000_0234;
    Ci = 1'b0; sub = 1'b1; start = 1'b1;
    dcnt = 0; second_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 2) second_at = k;
      end
    end
    start = 1'b0;
    model(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b1, es, ec, eo);
    check("held_done_cnt", 64'(dcnt), 64'd2);
    check("held_second_at", 64'(second_at), 64'd11);
    check("held_sout", 64'(Sout), 64'(es));
    prev_s = es; prev_c = ec; prev_o = eo;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom),
             0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_seq32.md
SUM_SEQ32 -- requirements
Module: sum_seq32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as below.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Ain  input  32  operand A; sampled on the accepting edge.
REQ-006 Bin  input  32  operand B; sampled on the accepting edge.
REQ-007 Ci  input  1  carry-in for add mode; sampled on the accepting edge; ignored when sub=1.
REQ-008 sub  input  1  mode; 0 = A+B+Ci, 1 = A-B; sampled on the accepting edge.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 Sout  output  32  result, registered.
REQ-012 Co  output  1  carry-out of bit 31, registered.
REQ-013 ovf  output  1  two's-complement overflow, registered.

Function
REQ-014 The block SHALL instantiate the existing 8-bit adder my_sum as its only adder datapath and use it once per cycle, byte-serially, LSB byte first.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after 4 byte cycles.
  - DONE -> IDLE unconditionally after 1 cycle.
REQ-016 On the accepting edge the block SHALL latch internal copies of Ain, Bin, sub and the initial carry.
  - Initial carry is Ci when sub=0 and 1 when sub=1.
  - The byte index resets to 0.
REQ-017 In RUN, for byte k (k = 0..3), the my_sum inputs SHALL be:
  - Ain = A[8k+7:8k].
  - Bin = B[8k+7:8k] when sub=0, or its bitwise inverse when sub=1.
  - Ci = the registered carry.
REQ-018 On each RUN edge the block SHALL store the my_sum Sout into internal byte k, store Co into the carry register, and increment k.
REQ-019 Latency: with start accepted at edge 0, bytes 0..3 SHALL be stored at edges 1..4, and done SHALL be high in the cycle after edge 4, exactly one cycle.
REQ-020 The output registers SHALL update only at edge 4, all in the same edge:
  - Sout = the full 32-bit internal result.
  - Co = the final carry.
  - ovf = (A[31] == B'[31]) && (Sout[31] != A[31]), where B' is the post-inversion operand.
REQ-021 Sout, Co and ovf SHALL hold their values until the next operation completes; partial results SHALL never appear on Sout.
REQ-022 In subtract mode, Co=1 SHALL mean no borrow (A >= B unsigned).
REQ-023 start asserted in RUN or DONE SHALL be ignored, with no queuing; a start held high continuously SHALL be accepted again in the first IDLE cycle.
REQ-024 Changes on Ain, Bin, Ci or sub after the accepting edge SHALL NOT affect the operation in progress.
REQ-025 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both SHALL be 0 in IDLE.

Reset
REQ-026 rst=1 SHALL immediately force, without waiting for a clock edge:
  - state IDLE, byte index 0, carry register 0, internal operands and result 0.
  - busy=0, done=0, Sout=0x00000000, Co=0, ovf=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation without producing a done pulse; the first start after reset release SHALL behave as from power-up.

Verification
REQ-028 Add: Ain=0x000000FF, Bin=0x00000001, Ci=0, sub=0 -> done 5 cycles after start, Sout=0x00000100, Co=0, ovf=0; busy high for exactly 4 cycles.
REQ-029 Full carry ripple: Ain=0xFFFFFFFF, Bin=0x00000000, Ci=1 -> Sout=0x00000000, Co=1, ovf=0.
REQ-030 Signed overflow: Ain=0x7FFFFFFF, Bin=0x00000001, Ci=0 -> Sout=0x80000000, Co=0, ovf=1; then sub=1, Ain=0x80000000, Bin=0x00000001 -> Sout=0x7FFFFFFF, Co=1, ovf=1.
REQ-031 Subtract with borrow: sub=1, Ain=5, Bin=7, Ci=1 (ignored) -> Sout=0xFFFFFFFE, Co=0, ovf=0.
REQ-032 Start while busy: start pulsed again 2 cycles after acceptance with different operands -> ignored, first result unchanged, exactly one done pulse; Sout holds the previous result during RUN.
REQ-033 Reset mid-RUN: rst asserted after 2 byte cycles -> all outputs 0 immediately, no done pulse; the next start then yields a correct result.
